// File: rtl/test_result_pkg.sv
// Shared types and width helper for the test result checker.
package test_result_pkg;

  // Run control states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Bits needed to index n values; never below 1 so degenerate parameters still elaborate
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : int'($clog2(n));
    return w;
  endfunction

endpackage

// File: rtl/test_result_popcount.sv
// Combinational zero-bit statistics of one result vector.
// Ports:
//   bits           - result vector, bit i = test i passed
//   zero_cnt_c     - number of zero (failing) bits
//   low_zero_idx_c - lowest index holding a zero (0 when none)
//   any_zero_c     - at least one bit is zero
module test_result_popcount
  import test_result_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 12
) (
  input  logic [NUM_TESTS-1:0]              bits,
  output logic [cnt_w(NUM_TESTS+1)-1:0]     zero_cnt_c,
  output logic [cnt_w(NUM_TESTS)-1:0]       low_zero_idx_c,
  output logic                              any_zero_c
);

  localparam int unsigned ZC_W  = cnt_w(NUM_TESTS + 1);
  localparam int unsigned IDX_W = cnt_w(NUM_TESTS);

  logic [ZC_W-1:0]  cnt;
  logic [IDX_W-1:0] idx;
  logic             any;

  // Scan from MSB down so the last hit is the lowest zero index
  always_comb begin
    cnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = int'(NUM_TESTS) - 1; i >= 0; i--) begin
      if (!bits[i]) begin
        cnt = cnt + ZC_W'(1);
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

  assign zero_cnt_c     = cnt;
  assign low_zero_idx_c = idx;
  assign any_zero_c     = any;

endmodule

// File: rtl/test_result_checker.sv
// Collects NUM_ROUNDS result vectors per run and reports pass/fail statistics,
// with an idle watchdog that ends a stalled run.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   start             - begin a run (honoured in IDLE/DONE only)
//   res_valid/res_bits- producer handshake and result vector (1 = test passed)
//   res_ready         - checker accepts a vector this cycle (COLLECT)
//   busy / done       - run in progress / run finished (held until next start)
//   pass              - all vectors all-ones and no timeout
//   fail_count        - total zero bits across accepted vectors
//   first_fail_idx    - lowest zero index of the first failing vector
//   first_fail_round  - round of the first failing vector
//   timeout           - run ended by the watchdog
module test_result_checker
  import test_result_pkg::*;
#(
  parameter int unsigned NUM_TESTS      = 12,
  parameter int unsigned NUM_ROUNDS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       res_valid,
  input  logic [NUM_TESTS-1:0]                       res_bits,
  output logic                                       res_ready,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       pass,
  output logic [cnt_w(NUM_TESTS*NUM_ROUNDS+1)-1:0]   fail_count,
  output logic [cnt_w(NUM_TESTS)-1:0]                first_fail_idx,
  output logic [cnt_w(NUM_ROUNDS)-1:0]               first_fail_round,
  output logic                                       timeout
);

  localparam int unsigned FC_W  = cnt_w(NUM_TESTS * NUM_ROUNDS + 1);
  localparam int unsigned IDX_W = cnt_w(NUM_TESTS);
  localparam int unsigned FR_W  = cnt_w(NUM_ROUNDS);
  localparam int unsigned RC_W  = cnt_w(NUM_ROUNDS + 1);
  localparam int unsigned WD_W  = cnt_w(TIMEOUT_CYCLES);
  localparam int unsigned ZC_W  = cnt_w(NUM_TESTS + 1);

  state_e             state_q, state_d;
  logic [RC_W-1:0]    rnd_q, rnd_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [FC_W-1:0]    fail_count_q, fail_count_d;
  logic [IDX_W-1:0]   ffi_q, ffi_d;
  logic [FR_W-1:0]    ffr_q, ffr_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;

  logic [ZC_W-1:0]    zero_cnt;
  logic [IDX_W-1:0]   low_zero_idx;
  logic               any_zero;
  logic               accept;

  test_result_popcount #(
    .NUM_TESTS (NUM_TESTS)
  ) u_popcount (
    .bits           (res_bits),
    .zero_cnt_c     (zero_cnt),
    .low_zero_idx_c (low_zero_idx),
    .any_zero_c     (any_zero)
  );

  assign res_ready = (state_q == ST_COLLECT);
  assign accept    = res_valid & res_ready;

  // Next-state and run bookkeeping
  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    wd_d         = wd_q;
    fail_count_d = fail_count_q;
    ffi_d        = ffi_q;
    ffr_d        = ffr_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_COLLECT;
          rnd_d        = '0;
          wd_d         = '0;
          fail_count_d = '0;
          ffi_d        = '0;
          ffr_d        = '0;
          pass_d       = 1'b1;
          timeout_d    = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          fail_count_d = fail_count_q + FC_W'(zero_cnt);
          rnd_d        = rnd_q + RC_W'(1);
          wd_d         = '0;
          // pass_q still set means no earlier vector has failed in this run
          if (any_zero && pass_q) begin
            ffi_d  = low_zero_idx;
            ffr_d  = FR_W'(rnd_q);
            pass_d = 1'b0;
          end
          if (rnd_q == RC_W'(NUM_ROUNDS - 1)) begin
            state_d = ST_DONE;
          end
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rnd_q        <= '0;
      wd_q         <= '0;
      fail_count_q <= '0;
      ffi_q        <= '0;
      ffr_q        <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      wd_q         <= wd_d;
      fail_count_q <= fail_count_d;
      ffi_q        <= ffi_d;
      ffr_q        <= ffr_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  assign busy             = (state_q == ST_COLLECT);
  assign done             = (state_q == ST_DONE);
  assign pass             = pass_q;
  assign timeout          = timeout_q;
  assign fail_count       = fail_count_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_round = ffr_q;

endmodule
